// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every minterm of an N_IN-input function, captures
// the response on f_in and scores it against an expected table latched at start.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(2**N_IN)-1:0]   expected,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   vec_valid,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic [N_IN:0]          mismatch_cnt,
  output logic                   pass
);

  localparam int              T           = 2**N_IN;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_idx;
  logic [3:0]        r_settle;
  logic [T-1:0]      r_exp;
  logic [N_IN-1:0]   r_vec;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic [T-1:0]      r_table;
  logic [N_IN:0]     r_mm;
  logic              r_pass;
  logic              w_miss;

  // Case inequality so an undriven/unknown response is scored as a miss.
  assign w_miss = (f_in !== r_exp[r_idx]);

  // Sequencer state, sweep bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_settle <= 4'd0;
      r_exp    <= '0;
      r_vec    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= '0;
      r_mm     <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_APPLY;
            r_exp    <= expected;
            r_idx    <= '0;
            r_settle <= 4'd0;
            r_table  <= '0;
            r_mm     <= '0;
            r_pass   <= 1'b0;
            r_vec    <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_APPLY: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_settle == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        S_SAMPLE: begin
          // Abort wins over the capture: the current row is left untouched.
          if (abort) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_table[r_idx] <= f_in;
            if (w_miss) begin
              r_mm <= r_mm + 1'b1;
            end
            if (r_idx == IDX_LAST) begin
              r_state <= S_FINISH;
              r_vec   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_APPLY;
              r_idx    <= r_idx + 1'b1;
              r_vec    <= r_idx + 1'b1;
              r_settle <= 4'd0;
            end
          end
        end
        S_FINISH: begin
          r_pass  <= (r_mm == '0);
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vec_out      = r_vec;
  assign vec_valid    = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign table_out    = r_table;
  assign mismatch_cnt = r_mm;
  assign pass         = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 4-input PoS function (table 16'hC3FF)
// is modelled on f_in and the sweeper's capture, score and timing are checked.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        f_in;
  logic [3:0]  vec_out;
  logic        vec_valid;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;
  logic        pass;

  logic [15:0] fn;
  logic        force_x;
  logic        fx;
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          base;

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .f_in         (f_in),
    .vec_out      (vec_out),
    .vec_valid    (vec_valid),
    .busy         (busy),
    .done         (done),
    .table_out    (table_out),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
  );

  // Function under exercise: combinational lookup, optionally unknown on row 3.
  assign f_in = (force_x && (vec_out == 4'd3)) ? fx : fn[vec_out];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse start for one edge; afterwards we sit in cycle 1 of the sweep.
  task automatic launch(input logic [15:0] exp_tbl);
    expected = exp_tbl;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    base     = cyc - 1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int busy_n;
    int bad;
    logic [15:0] exp_tbl;
    int exp_mm;

    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    fn       = 16'hC3FF;
    force_x  = 1'b0;
    fx       = 1'bx;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 16'h0000;

    // Reset state
    #12;
    check("rst0_busy", {31'd0, busy}, 32'd0);
    check("rst0_tbl", {16'd0, table_out}, 32'd0);
    check("rst0_pass", {31'd0, pass}, 32'd0);
    rst_n = 1'b1;

    // 1: asynchronous reset mid-APPLY at idx 7
    launch(16'hC3FF);
    repeat (14) tick();
    check("t1_vec7", {28'd0, vec_out}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("t1_vec", {28'd0, vec_out}, 32'd0);
    check("t1_valid", {31'd0, vec_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd0);
    check("t1_tbl", {16'd0, table_out}, 32'd0);
    check("t1_mm", {27'd0, mismatch_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 2: matching table, full timing walk, abort in FINISH ignored
    launch(16'hC3FF);
    busy_n = 0;
    bad    = 0;
    for (int c = 1; c <= 32; c++) begin
      if (busy) busy_n++;
      if (vec_out !== 4'((c - 1) / 2) || vec_valid !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    check("t2_seq", bad, 0);
    check("t2_busy_n", busy_n, 32);
    check("t2_done33", {31'd0, done}, 32'd1);
    check("t2_busy_off", {31'd0, busy}, 32'd0);
    check("t2_vec_fin", {27'd0, vec_valid, vec_out}, 32'd0);
    check("t2_tbl", {16'd0, table_out}, 32'h0000C3FF);
    check("t2_mm", {27'd0, mismatch_cnt}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t2_done_pulse", {31'd0, done}, 32'd0);
    check("t2_pass", {31'd0, pass}, 32'd1);

    // 3: expected all ones; a start pulse mid-sweep is ignored
    launch(16'hFFFF);
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("t3_cyc", cyc - base, 33);
    check("t3_tbl", {16'd0, table_out}, 32'h0000C3FF);
    check("t3_mm", {27'd0, mismatch_cnt}, 32'd4);
    tick();
    check("t3_pass", {31'd0, pass}, 32'd0);

    // 4: start held, expected changed after acceptance, back-to-back sweeps
    expected = 16'hC3FF;
    start    = 1'b1;
    tick();
    base = cyc - 1;
    repeat (4) tick();
    expected = 16'h0000;
    wait_done();
    check("t4_cyc", cyc - base, 33);
    check("t4_mm1", {27'd0, mismatch_cnt}, 32'd0);
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_pass1", {31'd0, pass}, 32'd1);
    tick();
    start = 1'b0;
    check("t4_rearm", {31'd0, busy}, 32'd1);
    check("t4_pclr", {31'd0, pass}, 32'd0);
    wait_done();
    check("t4_mm2", {27'd0, mismatch_cnt}, 32'd12);
    tick();
    check("t4_pass2", {31'd0, pass}, 32'd0);

    // 5: abort during SAMPLE of idx 5
    launch(16'hFFFF);
    repeat (11) tick();
    check("t5_vec5", {28'd0, vec_out}, 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_valid", {31'd0, vec_valid}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_lo", {27'd0, table_out[4:0]}, 32'h1F);
    check("t5_hi", {21'd0, table_out[15:5]}, 32'd0);
    check("t5_mm", {27'd0, mismatch_cnt}, 32'd0);
    check("t5_pass", {31'd0, pass}, 32'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    check("t5_quiet", bad, 0);

    // 6: unknown response on row 3; start and abort together in IDLE
    force_x = 1'b1;
    abort   = 1'b1;
    launch(16'hC3FF);
    abort   = 1'b0;
    check("t6_accept", {31'd0, busy}, 32'd1);
    wait_done();
    exp_tbl    = 16'hC3FF;
    exp_tbl[3] = fx;
    exp_mm     = (fx !== 1'b1) ? 1 : 0;
    check("t6_tbl", {16'd0, table_out}, {16'd0, exp_tbl});
    check("t6_mm", {27'd0, mismatch_cnt}, exp_mm);
    tick();
    check("t6_pass", {31'd0, pass}, (exp_mm == 0) ? 32'd1 : 32'd0);
    force_x = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
